// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin owner of a 3-digit 7-segment field for two requesters.
// The owner's binary value is converted by sequential double-dabble and shown with leading-zero blanking.
module seg_disp_sched #(
  parameter int HOLD_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [9:0] val0,
  input  logic [9:0] val1,
  output logic [1:0] gnt,
  output logic [7:0] seg_100,
  output logic [7:0] seg_10,
  output logic [7:0] seg_1,
  output logic       busy,
  output logic       ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;

  localparam int              HW        = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYC);
  localparam logic [7:0]      SEG_DASH  = 8'h40;
  localparam logic [3:0]      LAST_BIT  = 4'd9;
  localparam logic [9:0]      MAX_SHOWN = 10'd999;

  logic [1:0]    state_reg, state_next;
  logic [1:0]    gnt_reg, gnt_next;
  logic          last_reg, last_next;
  logic [9:0]    val_reg, val_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [11:0]   bcd_reg, bcd_next;
  logic [9:0]    bin_reg, bin_next;
  logic [3:0]    bit_reg, bit_next;
  logic [7:0]    s100_reg, s100_next;
  logic [7:0]    s10_reg, s10_next;
  logic [7:0]    s1_reg, s1_next;
  logic          ovf_reg, ovf_next;

  logic          owner;
  logic          other;
  logic [9:0]    owner_val;
  logic          owner_req;
  logic          other_req;
  logic          hold_done;
  logic [HW-1:0] hold_inc;
  logic          pick;
  logic          do_grant;
  logic          grant_idx;

  logic [11:0]   bcd_adj;
  logic [11:0]   bcd_step;
  logic [9:0]    bin_step;
  logic          bcd_carry;
  logic [3:0]    dig_100, dig_10, dig_1;
  logic [7:0]    conv_100, conv_10, conv_1;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 8'h3F;
      4'd1:    seg_enc = 8'h06;
      4'd2:    seg_enc = 8'h5B;
      4'd3:    seg_enc = 8'h4F;
      4'd4:    seg_enc = 8'h66;
      4'd5:    seg_enc = 8'h6D;
      4'd6:    seg_enc = 8'h7D;
      4'd7:    seg_enc = 8'h07;
      4'd8:    seg_enc = 8'h7F;
      4'd9:    seg_enc = 8'h6F;
      default: seg_enc = 8'h00;
    endcase
  endfunction

  // gnt is one-hot, so its upper bit is the owner index
  assign owner     = gnt_reg[1];
  assign other     = ~gnt_reg[1];
  assign owner_val = owner ? val1 : val0;
  assign owner_req = req[owner];
  assign other_req = req[other];
  assign hold_done = (hold_reg == HOLD_MAX);
  assign hold_inc  = hold_done ? hold_reg : hold_reg + HW'(1);
  assign pick      = (req == 2'b11) ? ~last_reg : req[1];

  // One double-dabble step: add 3 to any nibble >= 5, then shift in the next binary bit
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign {bcd_carry, bcd_step} = {bcd_adj, bin_reg[9]};
  assign bin_step = {bin_reg[8:0], 1'b0};

  assign dig_100  = bcd_step[11:8];
  assign dig_10   = bcd_step[7:4];
  assign dig_1    = bcd_step[3:0];
  assign conv_100 = (dig_100 == 4'd0) ? 8'h00 : seg_enc(dig_100);
  assign conv_10  = (dig_100 == 4'd0 && dig_10 == 4'd0) ? 8'h00 : seg_enc(dig_10);
  assign conv_1   = seg_enc(dig_1);

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    val_next   = val_reg;
    hold_next  = hold_reg;
    bcd_next   = bcd_reg;
    bin_next   = bin_reg;
    bit_next   = bit_reg;
    s100_next  = s100_reg;
    s10_next   = s10_reg;
    s1_next    = s1_reg;
    ovf_next   = ovf_reg;
    do_grant   = 1'b0;
    grant_idx  = pick;

    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          do_grant  = 1'b1;
          grant_idx = pick;
        end
      end

      CONV: begin
        hold_next = hold_inc;
        if (val_reg > MAX_SHOWN) begin
          s100_next  = SEG_DASH;
          s10_next   = SEG_DASH;
          s1_next    = SEG_DASH;
          ovf_next   = 1'b1;
          state_next = SHOW;
        end else begin
          bcd_next = bcd_step;
          bin_next = bin_step;
          bit_next = bit_reg + 4'd1;
          // All three digits land together on the final step
          if (bit_reg == LAST_BIT) begin
            s100_next  = conv_100;
            s10_next   = conv_10;
            s1_next    = conv_1;
            ovf_next   = bcd_carry;
            state_next = SHOW;
          end
        end
      end

      SHOW: begin
        if (hold_done && other_req) begin
          do_grant  = 1'b1;
          grant_idx = other;
        end else if (owner_req && (owner_val != val_reg)) begin
          // Owner changed its value: reconvert, old digits stay up meanwhile
          val_next   = owner_val;
          bcd_next   = 12'd0;
          bin_next   = owner_val;
          bit_next   = 4'd0;
          hold_next  = hold_inc;
          state_next = CONV;
        end else if (hold_done && !owner_req) begin
          gnt_next   = 2'b00;
          s100_next  = 8'h00;
          s10_next   = 8'h00;
          s1_next    = 8'h00;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end else begin
          hold_next = hold_inc;
        end
      end

      default: begin
        gnt_next   = 2'b00;
        s100_next  = 8'h00;
        s10_next   = 8'h00;
        s1_next    = 8'h00;
        ovf_next   = 1'b0;
        state_next = IDLE;
      end
    endcase

    if (do_grant) begin
      gnt_next   = grant_idx ? 2'b10 : 2'b01;
      last_next  = grant_idx;
      val_next   = grant_idx ? val1 : val0;
      bin_next   = grant_idx ? val1 : val0;
      bcd_next   = 12'd0;
      bit_next   = 4'd0;
      hold_next  = '0;
      ovf_next   = 1'b0;
      state_next = CONV;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      gnt_reg   <= 2'b00;
      last_reg  <= 1'b1;
      val_reg   <= 10'd0;
      hold_reg  <= '0;
      bcd_reg   <= 12'd0;
      bin_reg   <= 10'd0;
      bit_reg   <= 4'd0;
      s100_reg  <= 8'h00;
      s10_reg   <= 8'h00;
      s1_reg    <= 8'h00;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
      val_reg   <= val_next;
      hold_reg  <= hold_next;
      bcd_reg   <= bcd_next;
      bin_reg   <= bin_next;
      bit_reg   <= bit_next;
      s100_reg  <= s100_next;
      s10_reg   <= s10_next;
      s1_reg    <= s1_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign gnt     = gnt_reg;
  assign seg_100 = s100_reg;
  assign seg_10  = s10_reg;
  assign seg_1   = s1_reg;
  assign ovf     = ovf_reg;
  assign busy    = (state_reg != IDLE);

endmodule
